// File: rtl/iter_mul_div_unit_pkg.sv
// Shared opcodes, FSM encoding and counter width for the iterative mul/div/mod unit.
package iter_mul_div_unit_pkg;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;
  localparam int ITER_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Reserved opcode 2'b11 falls through to the multiply path.
  function automatic logic is_divmod(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction
endpackage

// File: rtl/iter_mul_div_unit_adder.sv
// Ripple-carry adder/subtracter: Sum = A + B (s=0) or A - B (s=1); Cout=1 means no borrow.
module Adder_Subtracter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             s,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] bx;

  assign bx   = B ^ {WIDTH{s}};
  assign c[0] = s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end

  assign Cout = c[WIDTH];
endmodule

// File: rtl/iter_mul_div_unit.sv
// Multi-cycle mul/div/mod execute unit: shift-add multiply and restoring divide
// sharing one adder/subtracter whose inputs are steered by FSM state.
module iter_mul_div_unit
  import iter_mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             div_by_zero
);
  state_t                state_q, state_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic                  q_neg_q, q_neg_d, a_neg_q, a_neg_d;
  logic [WIDTH-1:0]      p_q, p_d, m_q, m_d, d_q, d_d, r_q, r_d, q_q, q_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic                  dbz_q, dbz_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_s, add_cout;
  logic [WIDTH-1:0] r_shift, fix_val;
  logic             fix_neg, acc_div;

  Adder_Subtracter #(.WIDTH(WIDTH)) u_addsub (
    .A(add_a), .B(add_b), .s(add_s), .Sum(add_sum), .Cout(add_cout)
  );

  assign r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign fix_val = (op_q == OP_MOD) ? r_q : q_q;
  assign fix_neg = (op_q == OP_MOD) ? a_neg_q : q_neg_q;
  assign acc_div = is_divmod(op);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    q_neg_d  = q_neg_q;
    a_neg_d  = a_neg_q;
    p_d      = p_q;
    m_d      = m_q;
    d_d      = d_q;
    r_d      = r_q;
    q_d      = q_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    // Idle default negates the incoming A so |A| is ready at the accepting edge.
    add_a    = '0;
    add_b    = A;
    add_s    = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_PREP;
          op_d    = op;
          q_neg_d = acc_div & (A[WIDTH-1] ^ B[WIDTH-1]);
          a_neg_d = acc_div & A[WIDTH-1];
          m_d     = A;           // multiplicand, or raw dividend for mod-by-zero
          d_d     = B;           // multiplier, or raw divisor until PREP
          p_d     = '0;
          r_d     = '0;
          q_d     = (acc_div && A[WIDTH-1]) ? add_sum : A;
          dbz_d   = 1'b0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        add_b   = d_q;
        cnt_d   = '0;
        state_d = ST_ITER;
        if (is_divmod(op_q)) begin
          d_d = d_q[WIDTH-1] ? add_sum : d_q;
          if (d_q == '0) begin
            state_d  = ST_DONE;
            dbz_d    = 1'b1;
            result_d = (op_q == OP_MOD) ? m_q : '1;
          end
        end
      end
      ST_ITER: begin
        if (is_divmod(op_q)) begin
          add_a = r_shift;
          add_b = d_q;
          r_d   = add_cout ? add_sum : r_shift;
          q_d   = {q_q[WIDTH-2:0], add_cout};
        end else begin
          add_a = p_q;
          add_b = m_q;
          add_s = 1'b0;
          p_d   = d_q[0] ? add_sum : p_q;
          m_d   = m_q << 1;
          d_d   = d_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_CNT_W'(ITERS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        add_b    = fix_val;
        result_d = is_divmod(op_q) ? (fix_neg ? add_sum : fix_val) : p_q;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      q_neg_q  <= 1'b0;
      a_neg_q  <= 1'b0;
      p_q      <= '0;
      m_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      q_neg_q  <= q_neg_d;
      a_neg_q  <= a_neg_d;
      p_q      <= p_d;
      m_q      <= m_d;
      d_q      <= d_d;
      r_q      <= r_d;
      q_q      <= q_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign Result      = result_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_iter_mul_div_unit.sv
// Directed bench for iter_mul_div_unit: arithmetic model plus per-cycle compare and literal checks.
module tb_iter_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] A, B, Result;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int failures = 0;

  iter_mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .Result(Result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Returns {div_by_zero, result} straight from the arithmetic definition.
  function automatic logic [32:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] prod;
    if (o == 2'b01 || o == 2'b10) begin
      if (b == 32'd0) return {1'b1, (o == 2'b01) ? 32'hFFFFFFFF : a};
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {1'b0, (o == 2'b01) ? q[31:0] : r[31:0]};
    end
    prod = {32'd0, a} * {32'd0, b};
    return {1'b0, prod[31:0]};
  endfunction

  // Model state: m_t counts cycles since acceptance (1 = first busy cycle).
  bit          m_on = 0, m_act = 0, m_can;
  int          m_t = 0, m_lat = 0;
  logic [31:0] m_res = 0, m_new = 0;
  logic        m_dbz = 0, m_new_dbz = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1; m_act = 0; m_t = 0; m_res = 0; m_dbz = 0;
    end else if (m_on) begin
      m_can = !m_act || (m_t == m_lat);
      if (start && m_can) begin
        {m_new_dbz, m_new} = model(op, A, B);
        m_lat = m_new_dbz ? 2 : 35;
        m_act = 1; m_t = 1; m_dbz = 0;
      end else if (m_act) begin
        m_t++;
        if (m_t == m_lat) begin
          m_res = m_new; m_dbz = m_new_dbz;
        end else if (m_t > m_lat) begin
          m_act = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on && !reset) begin
      chk("cyc_busy", 32'(busy), 32'(m_act && m_t < m_lat));
      chk("cyc_done", 32'(done), 32'(m_act && m_t == m_lat));
      if (!(m_act && m_t < m_lat)) begin
        chk("cyc_result", Result, m_res);
        chk("cyc_dbz", 32'(div_by_zero), 32'(m_dbz));
      end
    end
  end

  task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(inout int n);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Leaves the bench at the negedge of the done cycle, so the next call starts back-to-back.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat,
                        input logic exp_dbz);
    int n;
    drive_start(o, a, b);
    n = 1;
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
    chk({nm, "_res"}, Result, exp_r);
    chk({nm, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul_7_m3",   2'b00, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 35, 1'b0);
    run_op("div_m7_2",   2'b01, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 35, 1'b0);
    run_op("mod_m7_2",   2'b10, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 35, 1'b0);
    run_op("mod_7_m2",   2'b10, 32'd7,          32'hFFFFFFFE, 32'd1,        35, 1'b0);
    run_op("div_5_0",    2'b01, 32'd5,          32'd0,        32'hFFFFFFFF, 2,  1'b1);
    run_op("mod_5_0",    2'b10, 32'd5,          32'd0,        32'd5,        2,  1'b1);
    run_op("div_ovf",    2'b01, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 35, 1'b0);
    run_op("mod_ovf",    2'b10, 32'h80000000,   32'hFFFFFFFF, 32'd0,        35, 1'b0);
    run_op("div_m100_m7",2'b01, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       35, 1'b0);
    run_op("mod_m100_m7",2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 35, 1'b0);
    run_op("div_big",    2'b01, 32'hFFFFFFFF,   32'h80000000, 32'd0,        35, 1'b0);
    run_op("rsv_3_5",    2'b11, 32'd3,          32'd5,        32'd15,       35, 1'b0);
    run_op("mul_x_0",    2'b00, 32'd12345,      32'd0,        32'd0,        35, 1'b0);
    run_op("mul_wrap",   2'b00, 32'h10000,      32'h10003,    32'h30000,    35, 1'b0);
    repeat (2) @(negedge clk);

    // A second start in cycle 10 lands while busy and must be dropped.
    drive_start(2'b00, 32'd100, 32'd3);
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd2;
    @(negedge clk); n++;
    start = 1'b0;
    wait_done(n);
    chk("ign_lat", 32'(n), 32'd35);
    chk("ign_res", Result, 32'd300);
    repeat (2) @(negedge clk);

    // Reset during cycle 12 of a divide aborts it with no done pulse.
    drive_start(2'b01, 32'd1000, 32'd7);
    n = 1;
    while (n < 12) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", Result, 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op("mul_6_7", 2'b00, 32'd6, 32'd7, 32'd42, 35, 1'b0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
